// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath: window geometry,
// decoder state encoding and the bipolar conversion used by both ends.
package sc_pkg;

   // Default VDC counter width; the window is 2^(N-2) beats long.
   localparam int unsigned N_DEFAULT = 6;
   localparam int unsigned W         = N_DEFAULT - 2;
   localparam int unsigned L         = 1 << W;

   typedef enum logic {
      IDLE,
      ACCUM
   } state_e;

   // Bipolar value of a window holding `ones` ones out of `len` beats: 2*ones - len.
   function automatic int to_bipolar(input int unsigned ones, input int unsigned len);
      return 2 * int'(ones) - int'(len);
   endfunction

endpackage

// File: rtl/sc_window_ctr.sv
// Window beat counter: counts enabled beats modulo 2^W and flags the beat that
// closes the window. Also used on the encoder side for window control.
module sc_window_ctr #(
   parameter int unsigned W = sc_pkg::W
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic last_beat
);

   logic [W-1:0] beat_q, beat_d;

   // Next beat count; clear has priority over counting.
   always_comb begin
      beat_d = beat_q;
      if (clear) begin
         beat_d = '0;
      end else if (enable) begin
         beat_d = beat_q + W'(1);
      end
   end

   // Beat counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         beat_q <= '0;
      end else begin
         beat_q <= beat_d;
      end
   end

   assign last_beat = enable && (beat_q == {W{1'b1}});

endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary converter: counts ones over a window of 2^(N-2) valid
// beats and presents the count (unipolar) or 2*ones-L (bipolar) on a
// valid/ready output with a sticky overrun flag.
module sc_bitstream_decoder
   import sc_pkg::*;
#(
   parameter int unsigned N          = W + 2,
   parameter bit          BIPOLAR    = 1'b0,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic         bit_in,
   input  logic         bit_valid,
   output logic [N-1:0] res_data,
   output logic         res_valid,
   input  logic         res_ready,
   output logic         busy,
   output logic         overrun
);

   localparam int unsigned WB  = N - 2;
   localparam int unsigned LEN = 1 << WB;

   state_e state_q, state_d;

   // One extra bit so an all-ones window (= LEN) does not wrap.
   logic [WB:0]  ones_q, ones_d, ones_sum;
   logic [N-1:0] res_data_q, res_data_d, result;
   logic         res_valid_q, res_valid_d;
   logic         overrun_q, overrun_d;
   logic         take, last_beat, ctr_clear;

   // start always wins, so a beat coinciding with start is never counted.
   assign take      = (state_q == ACCUM) && bit_valid && !start;
   assign ctr_clear = start || last_beat;
   assign ones_sum  = ones_q + (WB + 1)'(bit_in);

   sc_window_ctr #(
      .W(WB)
   ) u_window_ctr (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (ctr_clear),
      .enable   (take),
      .last_beat(last_beat)
   );

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = ACCUM;
         end
         ACCUM: begin
            if (!start && last_beat && !CONTINUOUS) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy      = (state_q == ACCUM);
      res_data  = res_data_q;
      res_valid = res_valid_q;
      overrun   = overrun_q;
   end

   // Window result including the final beat.
   always_comb begin
      result = BIPOLAR ? N'(to_bipolar(32'(ones_sum), LEN)) : N'(ones_sum);
   end

   // Ones accumulator and result/handshake next-state.
   always_comb begin
      ones_d      = ones_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      overrun_d   = overrun_q;

      if (ctr_clear) begin
         ones_d = '0;
      end else if (take) begin
         ones_d = ones_sum;
      end

      if (last_beat) begin
         res_data_d  = result;
         res_valid_d = 1'b1;
         // Overwriting a result the consumer has not taken.
         if (res_valid_q && !res_ready) overrun_d = 1'b1;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end

      if (start) overrun_d = 1'b0;
   end

   // Datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ones_q      <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         ones_q      <= ones_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         overrun_q   <= overrun_d;
      end
   end

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Bench for sc_bitstream_decoder: three instances (unipolar single-shot,
// bipolar single-shot, unipolar continuous) share one stimulus stream. Each has
// a window-queue reference model feeding a result scoreboard that a negedge
// monitor drains on every accepted result.
module tb_sc_bitstream_decoder;
   import sc_pkg::*;

   localparam int unsigned NW  = W + 2;
   localparam int unsigned LEN = L;

   logic clock     = 1'b0;
   logic reset_n   = 1'b1;
   logic start     = 1'b0;
   logic bit_in    = 1'b0;
   logic bit_valid = 1'b0;
   logic res_ready = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   task automatic check(input string name, input int g, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam bit BIP  = (g == 1);
      localparam bit CONT = (g == 2);

      logic [NW-1:0] res_data;
      logic          res_valid, busy, overrun;

      sc_bitstream_decoder #(
         .N         (NW),
         .BIPOLAR   (BIP),
         .CONTINUOUS(CONT)
      ) u_dut (
         .clock    (clock),
         .reset_n  (reset_n),
         .start    (start),
         .bit_in   (bit_in),
         .bit_valid(bit_valid),
         .res_data (res_data),
         .res_valid(res_valid),
         .res_ready(res_ready),
         .busy     (busy),
         .overrun  (overrun)
      );

      // Reference model: collect beats of the open window, count ones at L beats.
      bit            m_active  = 1'b0;
      bit            m_valid   = 1'b0;
      bit            m_overrun = 1'b0;
      bit            win[$];
      logic [NW-1:0] sb[$];

      always @(posedge clock or negedge reset_n) begin : p_model
         bit was_valid;
         int ones;
         if (!reset_n) begin
            m_active  = 1'b0;
            m_valid   = 1'b0;
            m_overrun = 1'b0;
            win.delete();
            sb.delete();
         end else begin
            was_valid = m_valid;
            if (m_valid && res_ready) m_valid = 1'b0;
            if (start) begin
               m_active  = 1'b1;
               m_overrun = 1'b0;
               win.delete();
            end else if (m_active && bit_valid) begin
               win.push_back(bit_in);
               if (win.size() == LEN) begin
                  ones = 0;
                  foreach (win[i]) ones += int'(win[i]);
                  if (was_valid && !res_ready) begin
                     m_overrun = 1'b1;
                     void'(sb.pop_back());
                  end
                  sb.push_back(BIP ? NW'(2 * ones - int'(LEN)) : NW'(ones));
                  m_valid = 1'b1;
                  win.delete();
                  if (!CONT) m_active = 1'b0;
               end
            end
         end
      end

      // Monitor: flags every cycle, data on every accept.
      always @(negedge clock) begin : p_mon
         logic [NW-1:0] exp;
         if (reset_n) begin
            check("busy", g, 32'(busy), 32'(m_active));
            check("res_valid", g, 32'(res_valid), 32'(m_valid));
            check("overrun", g, 32'(overrun), 32'(m_overrun));
            if (res_valid && res_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL sb_empty dut%0d: got result %0h with none expected", g,
                           res_data);
               end else begin
                  exp = sb.pop_front();
                  check("res_data", g, 32'(res_data), 32'(exp));
               end
            end
         end
      end
   end

   // One cycle of inputs, applied 1 time unit after the rising edge.
   task automatic drive(input bit st, input bit b, input bit v, input bit rdy);
      start     = st;
      bit_in    = b;
      bit_valid = v;
      res_ready = rdy;
      @(posedge clock);
      #1;
   endtask

   // VDC sequence bit: bit-reversed beat index compared against x.
   function automatic bit vdc_bit(input int i, input int x);
      int r;
      r = 0;
      for (int k = 0; k < int'(W); k++) if (i[k]) r |= 1 << (int'(W) - 1 - k);
      return r < x;
   endfunction

   task automatic beats(input int x, input bit rdy_last);
      for (int i = 0; i < int'(LEN); i++)
         drive(1'b0, vdc_bit(i, x), 1'b1, (i == int'(LEN) - 1) ? rdy_last : 1'b0);
   endtask

   // start carries a valid 1 beat that must not be counted.
   task automatic window_vdc(input int x);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      beats(x, 1'b0);
   endtask

   task automatic accept();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      check("rst_data", 0, 32'(g_dut[0].res_data), 32'h0);
      check("rst_valid", 0, 32'(g_dut[0].res_valid), 32'h0);
      check("rst_busy", 0, 32'(g_dut[0].busy), 32'h0);
      check("rst_overrun", 0, 32'(g_dut[0].overrun), 32'h0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
      check("idle_busy", 0, 32'(g_dut[0].busy), 32'h0);

      window_vdc(10);
      check("x10_valid", 0, 32'(g_dut[0].res_valid), 32'h1);
      check("x10_data", 0, 32'(g_dut[0].res_data), 32'd10);
      check("x10_busy", 0, 32'(g_dut[0].busy), 32'h0);
      check("x10_bip", 1, 32'(g_dut[1].res_data), 32'd4);
      accept();

      window_vdc(int'(LEN));
      check("ones_data", 0, 32'(g_dut[0].res_data), 32'd16);
      check("ones_bip", 1, 32'(g_dut[1].res_data), 32'd16);
      accept();

      window_vdc(0);
      check("zeros_data", 0, 32'(g_dut[0].res_data), 32'd0);
      check("zeros_bip", 1, 32'(g_dut[1].res_data), 32'h30);
      accept();

      window_vdc(8);
      check("x8_bip", 1, 32'(g_dut[1].res_data), 32'd0);
      accept();

      // Stalled all-ones window with a stall right before the last beat.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < int'(LEN); i++) begin
         if (i == int'(LEN) - 1) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_pre_valid", 0, 32'(g_dut[0].res_valid), 32'h0);
         end
         repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'b0, 1'b0);
         drive(1'b0, 1'b1, 1'b1, 1'b0);
      end
      check("stall_valid", 0, 32'(g_dut[0].res_valid), 32'h1);
      check("stall_data", 0, 32'(g_dut[0].res_data), 32'd16);
      accept();

      // Continuous back-to-back windows without accept.
      window_vdc(3);
      beats(12, 1'b0);
      check("cont_data", 2, 32'(g_dut[2].res_data), 32'd12);
      check("cont_overrun", 2, 32'(g_dut[2].overrun), 32'h1);
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      check("start_clr_ovr", 2, 32'(g_dut[2].overrun), 32'h0);
      beats(3, 1'b0);
      beats(12, 1'b1);
      check("acc_ovr", 2, 32'(g_dut[2].overrun), 32'h0);
      check("acc_data", 2, 32'(g_dut[2].res_data), 32'd12);
      check("acc_valid", 2, 32'(g_dut[2].res_valid), 32'h1);
      accept();

      // Restart after a partial all-ones window.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (9) drive(1'b0, 1'b1, 1'b1, 1'b0);
      window_vdc(5);
      check("restart_data", 0, 32'(g_dut[0].res_data), 32'd5);
      accept();

      // start on the window-end beat suppresses that result.
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (int'(LEN) - 1) drive(1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("start_end_valid", 0, 32'(g_dut[0].res_valid), 32'h0);
      check("start_end_busy", 0, 32'(g_dut[0].busy), 32'h1);

      // Asynchronous reset mid-window, away from the clock edge.
      repeat (5) drive(1'b0, 1'b1, 1'b1, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", 0, 32'(g_dut[0].busy), 32'h0);
      check("arst_busy_c", 2, 32'(g_dut[2].busy), 32'h0);
      check("arst_valid", 1, 32'(g_dut[1].res_valid), 32'h0);
      check("arst_data", 1, 32'(g_dut[1].res_data), 32'h0);
      @(posedge clock);
      #2 reset_n = 1'b1;
      @(posedge clock);
      #1;
      repeat (20) drive(1'b0, 1'b1, 1'b1, 1'b1);
      check("post_rst_busy", 0, 32'(g_dut[0].busy), 32'h0);
      check("post_rst_valid", 0, 32'(g_dut[0].res_valid), 32'h0);

      // Random traffic.
      repeat (1500)
         drive(($urandom_range(0, 24) == 0), 1'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 2) == 0));
      repeat (2) accept();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
